// File: rtl/seletor_jogador.sv
// ---------------------------------------------------------------------------
// seletor_jogador
//   Player-selection register for the game console. Converts N one-per-player
//   buttons into a binary player index for the game FSM. A press is debounced,
//   rejected if more than one button is held, and rejected if it names a dead
//   player. The FSM opens a selection window with `habilitar`. A rising edge
//   on `confirmar` then locks the current candidate and pulses
//   `escolha_pronta` once.
//
// Ports
//   clock              in   system clock, rising edge
//   reset              in   synchronous, active-high
//   botoes_jogadores   in   [N_JOGADORES] player buttons (already synchronised)
//   jogadores_vivos    in   [N_JOGADORES] alive mask, 0 = not selectable
//   habilitar          in   selection window open (level)
//   confirmar          in   confirm button (level, rising edge acts)
//   jogador_escolhido  out  [W_IDX] current candidate index
//   escolha_valida     out  candidate held and selectable
//   escolha_pronta     out  1-cycle pulse, candidate confirmed
//   erro_multiplo      out  1-cycle pulse, accepted press was not one-hot
//   erro_morto         out  1-cycle pulse, accepted press names a dead player
// ---------------------------------------------------------------------------
module seletor_jogador #(
  parameter int N_JOGADORES     = 5,
  parameter int W_IDX           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_JOGADORES-1:0] botoes_jogadores,
  input  logic [N_JOGADORES-1:0] jogadores_vivos,
  input  logic                   habilitar,
  input  logic                   confirmar,
  output logic [W_IDX-1:0]       jogador_escolhido,
  output logic                   escolha_valida,
  output logic                   escolha_pronta,
  output logic                   erro_multiplo,
  output logic                   erro_morto
);

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] ESPERA      = 2'd1;
  localparam logic [1:0] SELECIONADO = 2'd2;
  localparam logic [1:0] CONFIRMADO  = 2'd3;

  // The counter only needs to reach DEBOUNCE_CYCLES-1; it saturates there.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]          CNT_ALVO = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]          CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]          CNT_UM   = CW'(1);
  localparam logic [N_JOGADORES-1:0] B_ZERO   = {N_JOGADORES{1'b0}};
  localparam logic [W_IDX-1:0]       IDX_ZERO = {W_IDX{1'b0}};

  logic [N_JOGADORES-1:0] b_r;
  logic                   c_r;
  logic [CW-1:0]          cnt_r;
  logic                   armado_r;
  logic [1:0]             estado_r;

  logic                   conf_edge_s;
  logic                   aceite_s;
  logic                   press_um_quente_s;
  logic [W_IDX-1:0]       press_idx_s;
  logic                   press_vivo_s;
  logic                   cand_vivo_s;

  // True when exactly one bit of v is set.
  function automatic logic um_quente(input logic [N_JOGADORES-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 32'd1);
  endfunction

  // Index of the highest set bit (meaningful only for one-hot inputs).
  function automatic logic [W_IDX-1:0] indice_de(input logic [N_JOGADORES-1:0] v);
    logic [W_IDX-1:0] r;
    r = {W_IDX{1'b0}};
    for (int i = 0; i < N_JOGADORES; i++) begin
      if (v[i]) begin
        r = W_IDX'(i);
      end
    end
    return r;
  endfunction

  // Alive bit for an index; indices outside the player range read as dead.
  function automatic logic vivo_de(input logic [N_JOGADORES-1:0] mask,
                                   input logic [W_IDX-1:0]       idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      if (idx == W_IDX'(i)) begin
        r = mask[i];
      end
    end
    return r;
  endfunction

  // Decode the sampled press and the confirm edge for this clock edge.
  always_comb begin
    conf_edge_s       = confirmar & ~c_r;
    // An accept fires on the edge where b_r completes DEBOUNCE_CYCLES stable
    // samples, and only if the buttons were released since the last accept.
    aceite_s          = armado_r & (b_r != B_ZERO) & (cnt_r == CNT_ALVO);
    press_um_quente_s = um_quente(b_r);
    press_idx_s       = indice_de(b_r);
    press_vivo_s      = vivo_de(jogadores_vivos, press_idx_s);
    cand_vivo_s       = vivo_de(jogadores_vivos, jogador_escolhido);
  end

  // Input sampling, debounce counter and release-to-rearm flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_r      <= B_ZERO;
      c_r      <= 1'b0;
      cnt_r    <= CNT_ZERO;
      armado_r <= 1'b0;
    end else begin
      b_r <= botoes_jogadores;
      c_r <= confirmar;
      if ((botoes_jogadores != b_r) || (botoes_jogadores == B_ZERO)) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r != CNT_ALVO) begin
        cnt_r <= cnt_r + CNT_UM;
      end else begin
        cnt_r <= cnt_r;
      end
      // Rearm only on a sampled all-zero. It stays clear out of reset, so a
      // button still held through reset must be released first.
      if (botoes_jogadores == B_ZERO) begin
        armado_r <= 1'b1;
      end else if (aceite_s) begin
        armado_r <= 1'b0;
      end else begin
        armado_r <= armado_r;
      end
    end
  end

  // Selection FSM and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r          <= OCIOSO;
      jogador_escolhido <= IDX_ZERO;
      escolha_valida    <= 1'b0;
      escolha_pronta    <= 1'b0;
      erro_multiplo     <= 1'b0;
      erro_morto        <= 1'b0;
    end else begin
      escolha_pronta <= 1'b0;
      erro_multiplo  <= 1'b0;
      erro_morto     <= 1'b0;
      if (!habilitar) begin
        estado_r <= OCIOSO;
      end else begin
        case (estado_r)
          OCIOSO: begin
            estado_r          <= ESPERA;
            jogador_escolhido <= IDX_ZERO;
            escolha_valida    <= 1'b0;
          end
          ESPERA: begin
            if (aceite_s) begin
              if (!press_um_quente_s) begin
                erro_multiplo <= 1'b1;
              end else if (!press_vivo_s) begin
                erro_morto <= 1'b1;
              end else begin
                jogador_escolhido <= press_idx_s;
                escolha_valida    <= 1'b1;
                estado_r          <= SELECIONADO;
              end
            end else begin
              estado_r <= ESPERA;
            end
          end
          SELECIONADO: begin
            // A confirm beats a simultaneous accept, but a candidate that has
            // just died can never be confirmed.
            if (conf_edge_s && cand_vivo_s) begin
              escolha_pronta <= 1'b1;
              estado_r       <= CONFIRMADO;
            end else if (aceite_s && press_um_quente_s && press_vivo_s) begin
              jogador_escolhido <= press_idx_s;
              escolha_valida    <= 1'b1;
            end else begin
              erro_multiplo <= aceite_s & ~press_um_quente_s;
              erro_morto    <= aceite_s & press_um_quente_s & ~press_vivo_s;
              if (!cand_vivo_s) begin
                escolha_valida <= 1'b0;
                estado_r       <= ESPERA;
              end else begin
                estado_r <= SELECIONADO;
              end
            end
          end
          CONFIRMADO: begin
            estado_r <= CONFIRMADO;
          end
          default: begin
            estado_r       <= OCIOSO;
            escolha_valida <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
